// File: rtl/ltc2308_pkg.sv
// Shared types and constants for the LTC2308 serial-ADC responder.
// Config word layout is {S/D, O/S, S1, S0, UNI, SLP}.
package ltc2308_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    READY = 2'd2,
    SHIFT = 2'd3
  } state_t;

  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  localparam logic [5:0] CFG_RESET_DEFAULT = 6'b100010;

  function automatic logic [2:0] chan_of_cfg(input logic [5:0] cfg);
    return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
  endfunction

endpackage

// File: rtl/ltc2308_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin with optional
// single-cycle rise/fall pulses derived from the synchronized level.
module sync_edge #(
  parameter int STAGES   = 2,
  parameter bit EDGE_DET = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_level = r_sync[STAGES-1];

  generate
    if (EDGE_DET) begin : g_edge
      logic r_prev;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_prev <= 1'b0;
        end else begin
          r_prev <= o_level;
        end
      end

      assign o_rise = o_level & ~r_prev;
      assign o_fall = ~o_level & r_prev;
    end else begin : g_no_edge
      assign o_rise = 1'b0;
      assign o_fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/ltc2308_responder.sv
// Device-side model of the LTC2308 4-wire ADC interface: runs a timed
// conversion on CONVST, returns a 12-bit sample on SDO and captures SDI config.
module ltc2308_responder
  import ltc2308_pkg::*;
#(
  parameter int         TCONV_CYC   = 80,
  parameter int         SYNC_STAGES = 2,
  parameter logic [5:0] CFG_RESET   = CFG_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ADC_CONVST,
  input  logic        ADC_SCK,
  input  logic        ADC_SDI,
  output logic        ADC_SDO,
  output logic        conv_start,
  output logic [2:0]  conv_chan,
  input  logic [11:0] conv_data,
  output logic [5:0]  cfg_word,
  output logic        busy,
  output logic        frame_err
);

  localparam int             CNT_W    = $clog2(TCONV_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TCONV_CYC - 1);

  logic w_convst_lvl, w_convst_rise, w_convst_fall_unused;
  logic w_sck_lvl_unused, w_sck_rise, w_sck_fall;
  logic w_sdi_lvl, w_sdi_rise_unused, w_sdi_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sync_convst (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_async (ADC_CONVST),
    .o_level (w_convst_lvl),
    .o_rise  (w_convst_rise),
    .o_fall  (w_convst_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sync_sck (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_async (ADC_SCK),
    .o_level (w_sck_lvl_unused),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  // SDI goes through the same depth as SCK so it stays aligned with the SCK rise.
  sync_edge #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_sync_sdi (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_async (ADC_SDI),
    .o_level (w_sdi_lvl),
    .o_rise  (w_sdi_rise_unused),
    .o_fall  (w_sdi_fall_unused)
  );

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [11:0]      r_word, w_word_next;
  logic             r_sdo, w_sdo_next;
  logic [5:0]       r_sdi_sr, w_sdi_sr_next;
  logic [2:0]       r_sdi_cnt, w_sdi_cnt_next;
  logic [3:0]       r_sdo_cnt, w_sdo_cnt_next;
  logic [5:0]       r_cfg, w_cfg_next;
  logic [5:0]       r_pending, w_pending_next;
  logic [2:0]       r_conv_chan, w_conv_chan_next;
  logic             r_conv_start, w_conv_start_next;
  logic             r_frame_err, w_frame_err_next;
  logic             w_start_conv;
  logic [5:0]       w_sdi_shifted;

  assign w_sdi_shifted = {r_sdi_sr[4:0], w_sdi_lvl};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_word       <= '0;
      r_sdo        <= 1'b0;
      r_sdi_sr     <= '0;
      r_sdi_cnt    <= '0;
      r_sdo_cnt    <= '0;
      r_cfg        <= CFG_RESET;
      r_pending    <= CFG_RESET;
      r_conv_chan  <= '0;
      r_conv_start <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_word       <= w_word_next;
      r_sdo        <= w_sdo_next;
      r_sdi_sr     <= w_sdi_sr_next;
      r_sdi_cnt    <= w_sdi_cnt_next;
      r_sdo_cnt    <= w_sdo_cnt_next;
      r_cfg        <= w_cfg_next;
      r_pending    <= w_pending_next;
      r_conv_chan  <= w_conv_chan_next;
      r_conv_start <= w_conv_start_next;
      r_frame_err  <= w_frame_err_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_word_next       = r_word;
    w_sdo_next        = r_sdo;
    w_sdi_sr_next     = r_sdi_sr;
    w_sdi_cnt_next    = r_sdi_cnt;
    w_sdo_cnt_next    = r_sdo_cnt;
    w_cfg_next        = r_cfg;
    w_pending_next    = r_pending;
    w_conv_chan_next  = r_conv_chan;
    w_conv_start_next = 1'b0;
    w_frame_err_next  = 1'b0;
    w_start_conv      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_convst_rise) begin
          w_start_conv = 1'b1;
        end
      end

      CONV: begin
        if (w_convst_rise) begin
          w_frame_err_next = 1'b1;
        end
        if (r_cnt == CNT_LAST) begin
          w_word_next  = r_cfg[CFG_UNI] ? conv_data : (conv_data ^ 12'h800);
          w_state_next = READY;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      READY: begin
        if (w_convst_rise) begin
          w_frame_err_next = 1'b1;
        end else if (!w_convst_lvl) begin
          w_state_next = SHIFT;
          w_sdo_next   = r_word[11];
        end
      end

      SHIFT: begin
        // A CONVST rise takes priority; any SCK edge in the same cycle is dropped.
        if (w_convst_rise) begin
          w_start_conv = 1'b1;
          if ((r_sdi_cnt < 3'd6) || (r_sdo_cnt < 4'd12)) begin
            w_frame_err_next = 1'b1;
          end
        end else if (w_sck_fall && (r_sdo_cnt < 4'd12)) begin
          w_sdo_cnt_next = r_sdo_cnt + 1'b1;
          w_word_next    = {r_word[10:0], 1'b0};
          w_sdo_next     = (r_sdo_cnt == 4'd11) ? 1'b0 : r_word[10];
        end else if (w_sck_rise && (r_sdi_cnt < 3'd6)) begin
          w_sdi_cnt_next = r_sdi_cnt + 1'b1;
          w_sdi_sr_next  = w_sdi_shifted;
          if (r_sdi_cnt == 3'd5) begin
            w_pending_next = w_sdi_shifted;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Config captured in the previous frame becomes active for this conversion.
    if (w_start_conv) begin
      w_state_next      = CONV;
      w_cnt_next        = '0;
      w_cfg_next        = r_pending;
      w_conv_chan_next  = chan_of_cfg(r_pending);
      w_conv_start_next = 1'b1;
      w_sdo_next        = 1'b0;
      w_sdi_cnt_next    = '0;
      w_sdo_cnt_next    = '0;
    end
  end

  assign ADC_SDO    = r_sdo;
  assign conv_start = r_conv_start;
  assign conv_chan  = r_conv_chan;
  assign cfg_word   = r_cfg;
  assign busy       = (r_state != IDLE);
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ltc2308_responder.sv
// Initiator-side bench for ltc2308_responder: table of full frames plus
// hand sequences for abort, early CONVST and mid-frame reset.
module tb_ltc2308_responder;

  localparam int TCONV = 80;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        convst = 1'b0;
  logic        sck = 1'b0;
  logic        sdi = 1'b0;
  logic        sdo;
  logic        conv_start;
  logic [2:0]  conv_chan;
  logic [11:0] conv_data;
  logic [5:0]  cfg_word;
  logic        busy;
  logic        frame_err;

  logic [11:0] data_tbl [8];
  assign conv_data = data_tbl[conv_chan];

  ltc2308_responder #(.TCONV_CYC(TCONV), .SYNC_STAGES(2), .CFG_RESET(6'b100010)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ADC_CONVST (convst),
    .ADC_SCK    (sck),
    .ADC_SDI    (sdi),
    .ADC_SDO    (sdo),
    .conv_start (conv_start),
    .conv_chan  (conv_chan),
    .conv_data  (conv_data),
    .cfg_word   (cfg_word),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0;
  int n_ferr = 0;
  int start_cyc = 0;
  logic [2:0] st_chan = '0;
  logic [5:0] st_cfg = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (conv_start) begin
      n_start   <= n_start + 1;
      start_cyc <= cyc;
      st_chan   <= conv_chan;
      st_cfg    <= cfg_word;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
  end

  typedef struct {
    logic [5:0]  sdi;
    logic [2:0]  dch;
    logic [11:0] dval;
    logic [2:0]  echan;
    logic [5:0]  ecfg;
    logic [11:0] eword;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic convst_pulse();
    convst = 1'b1;
    tick(6);
    convst = 1'b0;
  endtask

  task automatic sck_cycles(input int n, input logic [5:0] cfg, output logic [11:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      sdi = (i < 6) ? cfg[5-i] : 1'b0;
      tick(20);
      if (i < 12) rx[11-i] = sdo;
      sck = 1'b1;
      tick(20);
      sck = 1'b0;
    end
    tick(20);
  endtask

  task automatic run_frame(input logic [5:0] cfg, output logic [11:0] rx,
                           output int dstart, output int dferr);
    int s0;
    int f0;
    s0 = n_start;
    f0 = n_ferr;
    convst_pulse();
    tick(100);
    sck_cycles(12, cfg, rx);
    dstart = n_start - s0;
    dferr  = n_ferr - f0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rx;
    int dstart, dferr, s0, f0, sdo_cyc;
    bit found;

    for (int i = 0; i < 8; i++) data_tbl[i] = 12'(i * 12'h111);

    vecs[0] = '{6'b110010, 3'd0, 12'hA5C, 3'd0, 6'b100010, 12'hA5C};
    vecs[1] = '{6'b100000, 3'd1, 12'h321, 3'd1, 6'b110010, 12'h321};
    vecs[2] = '{6'b100000, 3'd0, 12'h000, 3'd0, 6'b100000, 12'h800};
    vecs[3] = '{6'b100000, 3'd0, 12'hFFF, 3'd0, 6'b100000, 12'h7FF};
    vecs[4] = '{6'b101110, 3'd0, 12'h123, 3'd0, 6'b100000, 12'h923};
    vecs[5] = '{6'b111011, 3'd6, 12'h9E1, 3'd6, 6'b101110, 12'h9E1};
    vecs[6] = '{6'b100010, 3'd5, 12'h0F0, 3'd5, 6'b111011, 12'h0F0};
    vecs[7] = '{6'b100010, 3'd0, 12'h5A3, 3'd0, 6'b100010, 12'h5A3};

    // Reset state
    tick(5);
    check("rst_sdo", sdo, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cfg", cfg_word, 6'b100010);
    check("rst_chan", conv_chan, 3'd0);
    check("rst_conv_start", conv_start, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    reset_n = 1'b1;
    tick(10);
    check("rst_no_pulses", n_start + n_ferr, 0);
    $display("reset: sdo=%0b busy=%0b cfg=%b chan=%0d", sdo, busy, cfg_word, conv_chan);

    // Table of complete frames
    for (int v = 0; v < 8; v++) begin
      data_tbl[vecs[v].dch] = vecs[v].dval;
      run_frame(vecs[v].sdi, rx, dstart, dferr);
      check($sformatf("v%0d_word", v), rx, vecs[v].eword);
      check($sformatf("v%0d_chan", v), st_chan, vecs[v].echan);
      check($sformatf("v%0d_cfg", v), st_cfg, vecs[v].ecfg);
      check($sformatf("v%0d_starts", v), dstart, 1);
      check($sformatf("v%0d_ferr", v), dferr, 0);
      check($sformatf("v%0d_sdo_idle", v), sdo, 1'b0);
      $display("frame %0d: sdi=%b chan=%0d cfg=%b word=%03h", v, vecs[v].sdi, st_chan, st_cfg, rx);
    end

    // Abort after 3 SCK cycles: partial config must not reach pending
    data_tbl[0] = 12'h3C6;
    s0 = n_start;
    f0 = n_ferr;
    convst_pulse();
    tick(100);
    sck_cycles(3, 6'b111111, rx);
    check("abort_partial_bits", rx[11:9], 3'b001);
    data_tbl[0] = 12'hC00;
    convst_pulse();
    tick(100);
    check("abort_ferr", n_ferr - f0, 1);
    check("abort_starts", n_start - s0, 2);
    check("abort_cfg_kept", st_cfg, 6'b100010);
    check("abort_chan", st_chan, 3'd0);
    sck_cycles(12, 6'b100010, rx);
    check("abort_next_word", rx, 12'hC00);
    $display("abort: ferr=%0d starts=%0d cfg=%b word=%03h", n_ferr - f0, n_start - s0, st_cfg, rx);

    // Second CONVST rise 20 clk into the conversion
    s0 = n_start;
    f0 = n_ferr;
    convst = 1'b1;
    tick(6);
    convst = 1'b0;
    tick(14);
    convst = 1'b1;
    tick(6);
    convst = 1'b0;
    found = 1'b0;
    sdo_cyc = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(1);
      if (sdo) begin
        found = 1'b1;
        sdo_cyc = cyc;
      end
    end
    check("early_sdo_seen", found, 1'b1);
    check("early_ready_latency", sdo_cyc - start_cyc, TCONV + 1);
    check("early_starts", n_start - s0, 1);
    check("early_ferr", n_ferr - f0, 1);
    sck_cycles(12, 6'b111011, rx);
    check("early_word", rx, 12'hC00);
    $display("early: latency=%0d starts=%0d ferr=%0d word=%03h", sdo_cyc - start_cyc, n_start - s0, n_ferr - f0, rx);

    // Reset after 5 SDO bits of a CH5 frame
    data_tbl[5] = 12'h555;
    f0 = n_ferr;
    convst_pulse();
    tick(100);
    check("mid_cfg", st_cfg, 6'b111011);
    check("mid_chan", st_chan, 3'd5);
    sck_cycles(5, 6'b110010, rx);
    check("mid_bits", rx[11:7], 5'b01010);
    reset_n = 1'b0;
    tick(1);
    check("mid_rst_sdo", sdo, 1'b0);
    check("mid_rst_cfg", cfg_word, 6'b100010);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_chan", conv_chan, 3'd0);
    tick(3);
    reset_n = 1'b1;
    tick(5);
    check("mid_rst_no_ferr", n_ferr - f0, 0);
    $display("mid-reset: sdo=%0b cfg=%b busy=%0b", sdo, cfg_word, busy);

    data_tbl[0] = 12'h6B1;
    run_frame(6'b100010, rx, dstart, dferr);
    check("post_rst_word", rx, 12'h6B1);
    check("post_rst_chan", st_chan, 3'd0);
    check("post_rst_cfg", st_cfg, 6'b100010);
    check("post_rst_starts", dstart, 1);
    check("post_rst_ferr", dferr, 0);
    $display("post-reset frame: chan=%0d cfg=%b word=%03h", st_chan, st_cfg, rx);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
